// File: rtl/wb_pkg.sv
// Shared widths and the pending-write entry type for the write-back stage.
package wb_pkg;
  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 3;
  localparam int WB_DEPTH = 4;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// Circular pending-write buffer; exposes every slot in age order (index 0 = oldest)
// so the forwarding search can scan it combinationally.
module wb_fifo
  import wb_pkg::*;
#(
  parameter  int DEPTH = WB_DEPTH,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  wb_entry_t        push_entry,
  input  logic             pop,
  output wb_entry_t        head,
  output logic [CNT_W-1:0] count,
  output wb_entry_t        view [DEPTH],
  output logic [DEPTH-1:0] view_valid
);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  wb_entry_t        mem [DEPTH];

  // Storage carries no reset; only the pointers and count decide what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_entry;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];

  always_comb begin
    view_valid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      view[i]       = mem[PTR_W'(rd_ptr + PTR_W'(i))];
      view_valid[i] = (CNT_W'(i) < count);
    end
  end

endmodule

// File: rtl/writeback_unit.sv
// Write-back stage: selects ALU/memory result, queues register writes and drains them
// into the register file on cycles where decode leaves the port free; forwards pending values.
module writeback_unit
  import wb_pkg::*;
#(
  parameter  int DATA_W = wb_pkg::DATA_W,
  parameter  int ADDR_W = wb_pkg::ADDR_W,
  parameter  int DEPTH  = WB_DEPTH,
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wb_valid,
  output logic              wb_ready,
  input  logic              wb_reg_write,
  input  logic              wb_mem_to_reg,
  input  logic [DATA_W-1:0] wb_alu_result,
  input  logic [DATA_W-1:0] wb_mem_data,
  input  logic [ADDR_W-1:0] wb_dest,
  input  logic              rf_read_busy,
  output logic              rf_write_enable,
  output logic [ADDR_W-1:0] rf_write_addr,
  output logic [DATA_W-1:0] rf_write_data,
  input  logic [ADDR_W-1:0] fwd_addr1,
  input  logic [ADDR_W-1:0] fwd_addr2,
  output logic              fwd_hit1,
  output logic              fwd_hit2,
  output logic [DATA_W-1:0] fwd_data1,
  output logic [DATA_W-1:0] fwd_data2,
  output logic [CNT_W-1:0]  pending_count,
  output logic              empty
);

  wb_entry_t        push_entry;
  wb_entry_t        head;
  wb_entry_t        view [DEPTH];
  logic [DEPTH-1:0] view_valid;
  logic [CNT_W-1:0] count;
  logic             push;
  logic             pop;

  // Accept / select: non-writing instructions are consumed without a push.
  assign wb_ready        = (count < CNT_W'(DEPTH));
  assign push            = wb_valid && wb_ready && wb_reg_write;
  assign push_entry.addr = wb_dest;
  assign push_entry.data = wb_mem_to_reg ? wb_mem_data : wb_alu_result;

  // Drain only when decode is not reading; a same-edge push into an empty queue waits a cycle.
  assign pop = !rf_read_busy && (count != '0);

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .count      (count),
    .view       (view),
    .view_valid (view_valid)
  );

  // Register-file write port: one-cycle strobe per drained entry, addr/data hold otherwise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rf_write_enable <= 1'b0;
      rf_write_addr   <= '0;
      rf_write_data   <= '0;
    end else begin
      rf_write_enable <= pop;
      if (pop) begin
        rf_write_addr <= head.addr;
        rf_write_data <= head.data;
      end
    end
  end

  assign pending_count = count;
  assign empty         = (count == '0) && !rf_write_enable;

  // In-flight write is lowest priority; scanning oldest->youngest lets the youngest match win.
  always_comb begin
    fwd_hit1  = rf_write_enable && (rf_write_addr == fwd_addr1);
    fwd_hit2  = rf_write_enable && (rf_write_addr == fwd_addr2);
    fwd_data1 = fwd_hit1 ? rf_write_data : '0;
    fwd_data2 = fwd_hit2 ? rf_write_data : '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (view_valid[i] && (view[i].addr == fwd_addr1)) begin
        fwd_hit1  = 1'b1;
        fwd_data1 = view[i].data;
      end
      if (view_valid[i] && (view[i].addr == fwd_addr2)) begin
        fwd_hit2  = 1'b1;
        fwd_data2 = view[i].data;
      end
    end
  end

endmodule

// File: tb/tb_writeback_unit.sv
// Self-checking bench for writeback_unit against a queue-based reference model.
module tb_writeback_unit;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        wb_valid = 1'b0, wb_reg_write = 1'b0, wb_mem_to_reg = 1'b0;
  logic [15:0] wb_alu_result = '0, wb_mem_data = '0;
  logic [2:0]  wb_dest = '0, fwd_addr1 = '0, fwd_addr2 = '0;
  logic        rf_read_busy = 1'b0;
  logic        wb_ready, rf_write_enable, fwd_hit1, fwd_hit2, empty;
  logic [2:0]  rf_write_addr, pending_count;
  logic [15:0] rf_write_data, fwd_data1, fwd_data2;

  always #5 clk = ~clk;

  writeback_unit dut (
    .clk(clk), .reset(reset), .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg),
    .wb_alu_result(wb_alu_result), .wb_mem_data(wb_mem_data), .wb_dest(wb_dest),
    .rf_read_busy(rf_read_busy), .rf_write_enable(rf_write_enable),
    .rf_write_addr(rf_write_addr), .rf_write_data(rf_write_data),
    .fwd_addr1(fwd_addr1), .fwd_addr2(fwd_addr2), .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2),
    .fwd_data1(fwd_data1), .fwd_data2(fwd_data2), .pending_count(pending_count), .empty(empty)
  );

  // Reference model: a plain queue of pending writes plus the last issued write.
  typedef struct { logic [2:0] addr; logic [15:0] data; } ent_t;
  ent_t        q[$];
  logic        m_we = 1'b0;
  logic [2:0]  m_addr = '0;
  logic [15:0] m_data = '0;
  logic        last_accept = 1'b0;
  int          checks = 0, passes = 0;

  function automatic void model_reset();
    q.delete();
    m_we = 1'b0; m_addr = '0; m_data = '0;
  endfunction

  function automatic void fwd(input logic [2:0] a, output logic h, output logic [15:0] d);
    h = 1'b0; d = '0;
    for (int i = q.size() - 1; i >= 0; i--)
      if (q[i].addr == a) begin h = 1'b1; d = q[i].data; return; end
    if (m_we && m_addr == a) begin h = 1'b1; d = m_data; end
  endfunction

  function automatic logic [58:0] exp_vec();
    logic h1, h2; logic [15:0] d1, d2;
    fwd(fwd_addr1, h1, d1);
    fwd(fwd_addr2, h2, d2);
    return {q.size() < DEPTH, m_we, m_addr, m_data, 3'(q.size()),
            (q.size() == 0) && !m_we, h1, d1, h2, d2};
  endfunction

  wire [58:0] act_vec = {wb_ready, rf_write_enable, rf_write_addr, rf_write_data, pending_count,
                         empty, fwd_hit1, fwd_data1, fwd_hit2, fwd_data2};

  // One clock edge for DUT and model alike; returns 1 time unit after the edge.
  task automatic cycle();
    ent_t e;
    logic acc;
    @(posedge clk);
    acc = wb_valid && (q.size() < DEPTH);
    if (!rf_read_busy && q.size() > 0) begin
      e = q.pop_front(); m_we = 1'b1; m_addr = e.addr; m_data = e.data;
    end else m_we = 1'b0;
    if (acc && wb_reg_write) begin
      e.addr = wb_dest; e.data = wb_mem_to_reg ? wb_mem_data : wb_alu_result;
      q.push_back(e);
    end
    last_accept = acc;
    #1;
  endtask

  task automatic drive(input logic v, input logic rw, input logic m2r, input logic [2:0] d,
                       input logic [15:0] alu, input logic [15:0] mem);
    wb_valid = v; wb_reg_write = rw; wb_mem_to_reg = m2r; wb_dest = d;
    wb_alu_result = alu; wb_mem_data = mem;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (pending_count !== 3'd0) $display("FAIL reset_count act=%0d exp=0", pending_count); else passes++;
    checks++; if (rf_write_enable !== 1'b0) $display("FAIL reset_we act=%b exp=0", rf_write_enable); else passes++;
    checks++; if ({rf_write_addr, rf_write_data} !== 19'd0) $display("FAIL reset_addr_data act=%h/%h exp=0/0", rf_write_addr, rf_write_data); else passes++;
    checks++; if (empty !== 1'b1 || wb_ready !== 1'b1) $display("FAIL reset_empty_ready act=%b%b exp=11", empty, wb_ready); else passes++;
    @(negedge clk); reset = 1'b1;
    // Fill three entries while decode holds the port, then reset mid-queue.
    rf_read_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 0, 3'(i + 1), 16'h1000 + 16'(i), 16'h0);
      cycle();
    end
    drive(0, 0, 0, 0, 0, 0);
    checks++; if (pending_count !== 3'd3) $display("FAIL fill3_count act=%0d exp=3", pending_count); else passes++;
    #2 reset = 1'b0;
    model_reset();
    #1;
    checks++; if (pending_count !== 3'd0 || rf_write_enable !== 1'b0 || empty !== 1'b1)
      $display("FAIL midreset act=cnt%0d we%b empty%b exp=cnt0 we0 empty1", pending_count, rf_write_enable, empty);
    else passes++;
    @(negedge clk); reset = 1'b1; rf_read_busy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      checks++; if (rf_write_enable !== 1'b0) $display("FAIL postreset_no_write cyc=%0d act=%b exp=0", i, rf_write_enable); else passes++;
    end
  endtask

  task automatic test_select(input logic m2r, input logic [15:0] expd);
    rf_read_busy = 1'b0;
    drive(1, 1, m2r, 3'd5, 16'h1234, 16'hBEEF);
    cycle();
    drive(0, 0, 0, 0, 0, 0);
    checks++; if (rf_write_enable !== 1'b0 || pending_count !== 3'd1)
      $display("FAIL select_accept act=we%b cnt%0d exp=we0 cnt1", rf_write_enable, pending_count); else passes++;
    cycle();
    checks++; if (rf_write_enable !== 1'b1 || rf_write_addr !== 3'd5 || rf_write_data !== expd)
      $display("FAIL select_write act=we%b a%0d d%h exp=we1 a5 d%h", rf_write_enable, rf_write_addr, rf_write_data, expd);
    else passes++;
    cycle();
    checks++; if (rf_write_enable !== 1'b0 || empty !== 1'b1)
      $display("FAIL select_single_pulse act=we%b empty%b exp=we0 empty1", rf_write_enable, empty); else passes++;
  endtask

  task automatic test_nowrite();
    rf_read_busy = 1'b0;
    drive(1, 0, 1, 3'd3, 16'h7777, 16'h8888);
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++; if (last_accept !== 1'b1 || wb_ready !== 1'b1 || pending_count !== 3'd0 || rf_write_enable !== 1'b0)
        $display("FAIL nowrite act=ready%b cnt%0d we%b exp=ready1 cnt0 we0", wb_ready, pending_count, rf_write_enable);
      else passes++;
    end
    drive(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_full();
    logic [2:0]  ea [5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd6};
    logic [15:0] ed [5] = '{16'h11, 16'h22, 16'h33, 16'h44, 16'h66};
    int got = 0;
    rf_read_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 0, ea[i], ed[i], 16'hFFFF);
      cycle();
    end
    drive(1, 1, 0, 3'd6, 16'h66, 16'hFFFF);
    for (int i = 0; i < 2; i++) begin
      checks++; if (pending_count !== 3'd4 || wb_ready !== 1'b0 || rf_write_enable !== 1'b0)
        $display("FAIL full_stall act=cnt%0d ready%b we%b exp=cnt4 ready0 we0", pending_count, wb_ready, rf_write_enable);
      else passes++;
      cycle();
    end
    rf_read_busy = 1'b0;
    for (int n = 0; n < 12 && got < 5; n++) begin
      cycle();
      if (last_accept) wb_valid = 1'b0;
      if (rf_write_enable) begin
        checks++; if (rf_write_addr !== ea[got] || rf_write_data !== ed[got] || n != got)
          $display("FAIL drain_order idx=%0d act=a%0d d%h cyc%0d exp=a%0d d%h cyc%0d",
                   got, rf_write_addr, rf_write_data, n, ea[got], ed[got], got);
        else passes++;
        got++;
      end
    end
    checks++; if (got != 5) $display("FAIL drain_count act=%0d exp=5", got); else passes++;
    drive(0, 0, 0, 0, 0, 0);
    cycle();
  endtask

  task automatic test_forward();
    rf_read_busy = 1'b1;
    drive(1, 1, 0, 3'd3, 16'h3333, 0); cycle();
    drive(1, 1, 1, 3'd2, 0, 16'hAAAA); cycle();
    drive(1, 1, 0, 3'd2, 16'h5555, 0); cycle();
    drive(0, 0, 0, 0, 0, 0);
    fwd_addr1 = 3'd2; fwd_addr2 = 3'd7; #1;
    checks++; if (fwd_hit1 !== 1'b1 || fwd_data1 !== 16'h5555)
      $display("FAIL fwd_youngest act=%b/%h exp=1/5555", fwd_hit1, fwd_data1); else passes++;
    checks++; if (fwd_hit2 !== 1'b0 || fwd_data2 !== 16'h0)
      $display("FAIL fwd_miss act=%b/%h exp=0/0000", fwd_hit2, fwd_data2); else passes++;
    fwd_addr2 = 3'd3; #1;
    checks++; if (fwd_hit2 !== 1'b1 || fwd_data2 !== 16'h3333)
      $display("FAIL fwd_r3_queued act=%b/%h exp=1/3333", fwd_hit2, fwd_data2); else passes++;
    rf_read_busy = 1'b0;
    cycle();
    checks++; if ({fwd_hit1, fwd_data1, fwd_hit2, fwd_data2} !== {1'b1, 16'h5555, 1'b1, 16'h3333})
      $display("FAIL fwd_inflight_r3 act=%b/%h %b/%h exp=1/5555 1/3333", fwd_hit1, fwd_data1, fwd_hit2, fwd_data2);
    else passes++;
    cycle();
    checks++; if ({fwd_hit1, fwd_data1, fwd_hit2, fwd_data2} !== {1'b1, 16'h5555, 1'b0, 16'h0})
      $display("FAIL fwd_after_r3 act=%b/%h %b/%h exp=1/5555 0/0000", fwd_hit1, fwd_data1, fwd_hit2, fwd_data2);
    else passes++;
    cycle();
    checks++; if (fwd_hit1 !== 1'b1 || fwd_data1 !== 16'h5555 || rf_write_data !== 16'h5555)
      $display("FAIL fwd_inflight_r2 act=%b/%h exp=1/5555", fwd_hit1, fwd_data1); else passes++;
    cycle();
    checks++; if (fwd_hit1 !== 1'b0 || fwd_data1 !== 16'h0)
      $display("FAIL fwd_drained act=%b/%h exp=0/0000", fwd_hit1, fwd_data1); else passes++;
  endtask

  task automatic test_back_to_back();
    rf_read_busy = 1'b1;
    drive(1, 1, 0, 3'd1, 16'h0101, 0); cycle();
    drive(1, 1, 0, 3'd2, 16'h0202, 0); cycle();
    rf_read_busy = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (k < 3) drive(1, 1, 0, 3'(k + 3), 16'h0101 * 16'(k + 3), 0);
      else drive(0, 0, 0, 0, 0, 0);
      cycle();
      checks++; if (pending_count !== 3'((k < 3) ? 2 : 4 - k) || rf_write_enable !== 1'b1 ||
                    rf_write_addr !== 3'(k + 1) || rf_write_data !== 16'h0101 * 16'(k + 1))
        $display("FAIL push_pop k=%0d act=cnt%0d we%b a%0d d%h exp=cnt%0d we1 a%0d d%h", k, pending_count,
                 rf_write_enable, rf_write_addr, rf_write_data, (k < 3) ? 2 : 4 - k, k + 1, 16'h0101 * 16'(k + 1));
      else passes++;
    end
    cycle();
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      drive(($urandom % 4) != 0, ($urandom % 4) != 0, $urandom % 2, 3'($urandom),
            16'($urandom), 16'($urandom));
      rf_read_busy = ($urandom % 2) != 0;
      fwd_addr1 = 3'($urandom); fwd_addr2 = 3'($urandom);
      if ($urandom_range(0, 63) == 0) begin
        reset = 1'b0; model_reset(); #1;
        checks++; if (act_vec !== exp_vec()) $display("FAIL random_reset n=%0d act=%h exp=%h", n, act_vec, exp_vec()); else passes++;
        @(negedge clk); reset = 1'b1;
      end
      cycle();
      checks++; if (act_vec !== exp_vec()) $display("FAIL random n=%0d act=%h exp=%h", n, act_vec, exp_vec()); else passes++;
    end
    drive(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_select(1'b1, 16'hBEEF);
    test_select(1'b0, 16'h1234);
    test_nowrite();
    test_full();
    test_forward();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
